// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions between fetch, the 2-bit predictor and execute.
// Captures each prediction one cycle after the request, resolves from the head, flushes on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_fetch,
    output logic             br_ready,
    output logic             pred_request,
    input  logic             pred_in,
    output logic             br_pred_valid,
    output logic             br_pred_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic             pred_result,
    output logic             pred_taken,
    output logic             mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_known;
    logic [DEPTH-1:0] ent_pred;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             pend_valid;
    logic [PTR_W-1:0] pend_ptr;
    logic             accept;
    logic             pop;
    logic             mis;

    assign br_ready      = (count != (PTR_W+1)'(DEPTH));
    assign accept        = br_fetch & br_ready;
    assign pred_request  = accept;
    assign br_pred_valid = pend_valid;
    assign br_pred_taken = pend_valid & pred_in;
    // A head whose prediction has not yet been captured cannot be resolved.
    assign resolve_ready = ent_valid[head] & ent_known[head];
    assign pop           = resolve_valid & resolve_ready;
    assign pred_result   = pop;
    assign pred_taken    = resolve_taken;
    assign mis           = pop & (ent_pred[head] ^ resolve_taken);

    always_comb begin
        count_next = count;
        if (accept && !pop)
            count_next = count + 1'b1;
        else if (pop && !accept)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid        <= '0;
            ent_known        <= '0;
            ent_pred         <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            pend_valid       <= 1'b0;
            pend_ptr         <= '0;
            mispredict       <= 1'b0;
            flush            <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= mis;
            flush      <= mis;
            if (pop && branch_count != '1)
                branch_count <= branch_count + 1'b1;
            if (mis && mispredict_count != '1)
                mispredict_count <= mispredict_count + 1'b1;

            if (mis) begin
                // Everything younger than the head is wrong-path, including a same-cycle accept.
                ent_valid  <= '0;
                ent_known  <= '0;
                count      <= '0;
                head       <= tail;
                pend_valid <= 1'b0;
            end else begin
                if (pend_valid) begin
                    ent_pred[pend_ptr]  <= pred_in;
                    ent_known[pend_ptr] <= 1'b1;
                end
                if (pop) begin
                    ent_valid[head] <= 1'b0;
                    ent_known[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                if (accept) begin
                    ent_valid[tail] <= 1'b1;
                    ent_known[tail] <= 1'b0;
                    tail            <= tail + 1'b1;
                    pend_ptr        <= tail;
                end
                pend_valid <= accept;
                count      <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_fetch;
    logic        br_ready;
    logic        pred_request;
    logic        pred_in;
    logic        br_pred_valid;
    logic        br_pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_ready;
    logic        pred_result;
    logic        pred_taken;
    logic        mispredict;
    logic        flush;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    branch_resolve_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .br_fetch         (br_fetch),
        .br_ready         (br_ready),
        .pred_request     (pred_request),
        .pred_in          (pred_in),
        .br_pred_valid    (br_pred_valid),
        .br_pred_taken    (br_pred_taken),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_ready    (resolve_ready),
        .pred_result      (pred_result),
        .pred_taken       (pred_taken),
        .mispredict       (mispredict),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, leaving time 1 after the edge for driving inputs.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        br_fetch      = 1'b0;
        pred_in       = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    logic [3:0] preds;

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        check("rst_br_ready", 32'(br_ready), 32'd1);
        check("rst_resolve_ready", 32'(resolve_ready), 32'd0);
        check("rst_bcnt", 32'(branch_count), 32'd0);
        check("rst_mcnt", 32'(mispredict_count), 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);
        check("rst_br_pred_valid", 32'(br_pred_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        #1;
        check("idle_br_ready", 32'(br_ready), 32'd1);
        check("idle_pred_result", 32'(pred_result), 32'd0);

        // Single branch, resolve attempted during capture cycle, then accepted
        br_fetch = 1'b1;
        #1;
        check("one_pred_request", 32'(pred_request), 32'd1);
        tick();
        idle_inputs();
        pred_in       = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("one_pred_valid", 32'(br_pred_valid), 32'd1);
        check("one_pred_taken", 32'(br_pred_taken), 32'd1);
        check("one_unknown_ready", 32'(resolve_ready), 32'd0);
        check("one_unknown_result", 32'(pred_result), 32'd0);
        tick();
        pred_in = 1'b0;
        #1;
        check("one_ready", 32'(resolve_ready), 32'd1);
        check("one_result", 32'(pred_result), 32'd1);
        check("one_taken_out", 32'(pred_taken), 32'd1);
        check("one_pend_clear", 32'(br_pred_valid), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("one_no_mis", 32'(mispredict), 32'd0);
        check("one_bcnt", 32'(branch_count), 32'd1);
        check("one_empty", 32'(resolve_ready), 32'd0);

        // Four back-to-back, fifth refused, resolve all correctly
        preds = 4'b0110; // preds[0]=0, [1]=1, [2]=1, [3]=0
        for (int k = 0; k < 4; k++) begin
            br_fetch = 1'b1;
            pred_in  = (k > 0) ? preds[k-1] : 1'b0;
            #1;
            check("fill_pred_request", 32'(pred_request), 32'd1);
            check("fill_pred_valid", 32'(br_pred_valid), (k > 0) ? 32'd1 : 32'd0);
            tick();
        end
        br_fetch = 1'b1;
        pred_in  = preds[3];
        #1;
        check("full_br_ready", 32'(br_ready), 32'd0);
        check("full_pred_request", 32'(pred_request), 32'd0);
        check("full_last_valid", 32'(br_pred_valid), 32'd1);
        check("full_last_taken", 32'(br_pred_taken), 32'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            resolve_valid = 1'b1;
            resolve_taken = preds[k];
            #1;
            check("drain_result", 32'(pred_result), 32'd1);
            tick();
            #1;
            check("drain_no_mis", 32'(mispredict), 32'd0);
        end
        idle_inputs();
        #1;
        check("drain_bcnt", 32'(branch_count), 32'd5);
        check("drain_mcnt", 32'(mispredict_count), 32'd0);
        check("drain_empty", 32'(resolve_ready), 32'd0);

        // Refill across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            br_fetch = 1'b1;
            pred_in  = 1'b1;
            #1;
            check("refill_pred_request", 32'(pred_request), 32'd1);
            tick();
        end
        idle_inputs();
        pred_in = 1'b1;
        #1;
        check("refill_full", 32'(br_ready), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            #1;
            check("refill_result", 32'(pred_result), 32'd1);
            tick();
        end
        idle_inputs();
        #1;
        check("refill_bcnt", 32'(branch_count), 32'd9);

        // Three entries, mispredict on the first flushes the rest
        for (int k = 0; k < 3; k++) begin
            br_fetch = 1'b1;
            pred_in  = 1'b0;
            tick();
        end
        idle_inputs();
        tick();
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("mis_ready", 32'(resolve_ready), 32'd1);
        check("mis_not_yet", 32'(mispredict), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("mis_pulse", 32'(mispredict), 32'd1);
        check("mis_flush", 32'(flush), 32'd1);
        check("mis_mcnt", 32'(mispredict_count), 32'd1);
        check("mis_bcnt", 32'(branch_count), 32'd10);
        check("mis_flushed", 32'(resolve_ready), 32'd0);
        check("mis_br_ready", 32'(br_ready), 32'd1);
        tick();
        #1;
        check("mis_pulse_end", 32'(mispredict), 32'd0);
        check("flush_pulse_end", 32'(flush), 32'd0);

        // Fetch squashed by a same-cycle mispredict
        br_fetch = 1'b1;
        tick();
        idle_inputs();
        pred_in = 1'b0;
        tick();
        br_fetch      = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("sq_pred_request", 32'(pred_request), 32'd1);
        check("sq_result", 32'(pred_result), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("sq_no_pred_valid", 32'(br_pred_valid), 32'd0);
        check("sq_mis", 32'(mispredict), 32'd1);
        check("sq_empty", 32'(resolve_ready), 32'd0);
        check("sq_mcnt", 32'(mispredict_count), 32'd2);
        // Count must be zero: exactly four more accepts fit
        for (int k = 0; k < 4; k++) begin
            br_fetch = 1'b1;
            pred_in  = 1'b1;
            #1;
            check("sq_refill_request", 32'(pred_request), 32'd1);
            tick();
        end
        idle_inputs();
        #1;
        check("sq_refill_full", 32'(br_ready), 32'd0);

        // Resolve head while capturing tail, then accept+resolve together
        pred_in       = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("cap_res_result", 32'(pred_result), 32'd1);
        tick();
        br_fetch      = 1'b1;
        pred_in       = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("both_request", 32'(pred_request), 32'd1);
        check("both_result", 32'(pred_result), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("both_bcnt", 32'(branch_count), 32'd13);
        check("both_no_mis", 32'(mispredict), 32'd0);
        check("both_pend", 32'(br_pred_valid), 32'd1);
        check("both_count3", 32'(br_ready), 32'd1);

        // Asynchronous reset mid-operation with three entries in flight
        rst = 1'b1;
        #1;
        check("mrst_pred_valid", 32'(br_pred_valid), 32'd0);
        check("mrst_br_ready", 32'(br_ready), 32'd1);
        check("mrst_resolve_ready", 32'(resolve_ready), 32'd0);
        check("mrst_bcnt", 32'(branch_count), 32'd0);
        check("mrst_mcnt", 32'(mispredict_count), 32'd0);
        tick();
        rst = 1'b0;
        resolve_valid = 1'b1;
        #1;
        check("mrst_no_result", 32'(pred_result), 32'd0);
        tick();
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
